// File: rtl/mbscore_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mbscore_wb_stage_if
// Brief    : EX-side, memory-side and reg-file-side bundle of the MBScore WB stage.
//            Forwarding signals exist only when MBSCORE_WB_BYPASS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface mbscore_wb_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int SEL_WIDTH      = 3
);
    logic                      in_valid;
    logic                      in_ready;
    logic [SEL_WIDTH-1:0]      in_sel;
    logic [REG_ADDR_WIDTH-1:0] in_rd;
    logic [DATA_WIDTH-1:0]     in_alu;
    logic [DATA_WIDTH-1:0]     in_addr;

    logic                      mem_req;
    logic                      mem_we;
    logic [DATA_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic                      mem_gnt;
    logic                      mem_rvalid;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    logic                      rf_we;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0]     rf_wdata;
    logic                      jump;
    logic                      wb_err;

`ifdef MBSCORE_WB_BYPASS_EN
    logic                      fwd_valid;
    logic [REG_ADDR_WIDTH-1:0] fwd_addr;
    logic [DATA_WIDTH-1:0]     fwd_data;
`endif

    // Writeback stage view
    modport slave (
`ifdef MBSCORE_WB_BYPASS_EN
        output fwd_valid, fwd_addr, fwd_data,
`endif
        input  in_valid, in_sel, in_rd, in_alu, in_addr,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output rf_we, rf_waddr, rf_wdata, jump, wb_err
    );

    // Environment view: EX stage, memory and register file
    modport master (
`ifdef MBSCORE_WB_BYPASS_EN
        input  fwd_valid, fwd_addr, fwd_data,
`endif
        output in_valid, in_sel, in_rd, in_alu, in_addr,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  rf_we, rf_waddr, rf_wdata, jump, wb_err
    );
endinterface
`default_nettype wire

// File: rtl/mbscore_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mbscore_wb_stage
// Brief    : Registered MBScore writeback stage: ALU->REG/MEM/IR routing and
//            load/store via req/gnt/rvalid with bounded wait. Optional
//            forwarding outputs enabled by MBSCORE_WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mbscore_wb_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int SEL_WIDTH      = 3,
    parameter int MEM_TIMEOUT    = 15,
    parameter int ZERO_REG       = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mbscore_wb_stage_if.slave bus
);

    localparam int c_CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0]   c_TIMEOUT     = c_CNT_W'(MEM_TIMEOUT);
    localparam logic [SEL_WIDTH-1:0] c_SEL_NOP     = SEL_WIDTH'(0);
    localparam logic [SEL_WIDTH-1:0] c_SEL_ALU_REG = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0] c_SEL_ALU_MEM = SEL_WIDTH'(2);
    localparam logic [SEL_WIDTH-1:0] c_SEL_MEM_REG = SEL_WIDTH'(3);
    localparam logic [SEL_WIDTH-1:0] c_SEL_ALU_IR  = SEL_WIDTH'(4);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MEM_REQ   = 2'd1,
        ST_WAIT_DATA = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [c_CNT_W-1:0]        w_cnt_nxt;
    logic [c_CNT_W-1:0]        w_cnt_inc;
    logic                      w_timeout;

    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic                      r_we;

    logic                      r_rf_we;
    logic [REG_ADDR_WIDTH-1:0] r_rf_waddr;
    logic [DATA_WIDTH-1:0]     r_rf_wdata;
    logic                      r_jump;
    logic                      r_err;

    logic                      w_rf_we_nxt;
    logic [REG_ADDR_WIDTH-1:0] w_rf_waddr_nxt;
    logic [DATA_WIDTH-1:0]     w_rf_wdata_nxt;
    logic                      w_jump_nxt;
    logic                      w_err_nxt;

    logic                      w_accept;
    logic                      w_in_rd_ok;
    logic                      w_cap_rd_ok;

    assign w_accept  = bus.in_valid && (r_state == ST_IDLE);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (w_cnt_inc == c_TIMEOUT);

    // Writes to r0 are squashed at the strobe only; address/data still update
    generate
        if (ZERO_REG != 0) begin : g_zero_reg
            assign w_in_rd_ok  = |bus.in_rd;
            assign w_cap_rd_ok = |r_rd;
        end else begin : g_no_zero_reg
            assign w_in_rd_ok  = 1'b1;
            assign w_cap_rd_ok = 1'b1;
        end
    endgenerate

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rf_we_nxt    = 1'b0;
        w_rf_waddr_nxt = r_rf_waddr;
        w_rf_wdata_nxt = r_rf_wdata;
        w_jump_nxt     = 1'b0;
        w_err_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt = '0;
                    case (bus.in_sel)
                        c_SEL_NOP: ;
                        c_SEL_ALU_REG: begin
                            w_rf_we_nxt    = w_in_rd_ok;
                            w_rf_waddr_nxt = bus.in_rd;
                            w_rf_wdata_nxt = bus.in_alu;
                        end
                        c_SEL_ALU_MEM,
                        c_SEL_MEM_REG: w_state_nxt = ST_MEM_REQ;
                        c_SEL_ALU_IR:  w_jump_nxt  = bus.in_alu[0];
                        default:       w_err_nxt   = 1'b1;
                    endcase
                end
            end

            // Completion is tested before the timeout so a same-cycle response wins
            ST_MEM_REQ: begin
                w_cnt_nxt = w_cnt_inc;
                if (bus.mem_gnt && r_we) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.mem_gnt && bus.mem_rvalid) begin
                    w_state_nxt    = ST_IDLE;
                    w_rf_we_nxt    = w_cap_rd_ok;
                    w_rf_waddr_nxt = r_rd;
                    w_rf_wdata_nxt = bus.mem_rdata;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                end else if (bus.mem_gnt) begin
                    w_state_nxt = ST_WAIT_DATA;
                end
            end

            ST_WAIT_DATA: begin
                w_cnt_nxt = w_cnt_inc;
                if (bus.mem_rvalid) begin
                    w_state_nxt    = ST_IDLE;
                    w_rf_we_nxt    = w_cap_rd_ok;
                    w_rf_waddr_nxt = r_rd;
                    w_rf_wdata_nxt = bus.mem_rdata;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rd       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_jump     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rf_we    <= w_rf_we_nxt;
            r_rf_waddr <= w_rf_waddr_nxt;
            r_rf_wdata <= w_rf_wdata_nxt;
            r_jump     <= w_jump_nxt;
            r_err      <= w_err_nxt;
            if (w_accept) begin
                r_rd    <= bus.in_rd;
                r_addr  <= bus.in_addr;
                r_wdata <= bus.in_alu;
                r_we    <= (bus.in_sel == c_SEL_ALU_MEM);
            end
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.mem_req   = (r_state == ST_MEM_REQ);
    assign bus.mem_we    = (r_state == ST_MEM_REQ) && r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.rf_we     = r_rf_we;
    assign bus.rf_waddr  = r_rf_waddr;
    assign bus.rf_wdata  = r_rf_wdata;
    assign bus.jump      = r_jump;
    assign bus.wb_err    = r_err;

`ifdef MBSCORE_WB_BYPASS_EN
    assign bus.fwd_valid = r_rf_we;
    assign bus.fwd_addr  = r_rf_waddr;
    assign bus.fwd_data  = r_rf_wdata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mbscore_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mbscore_wb_stage
// Brief    : Directed self-checking bench for mbscore_wb_stage (default config).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mbscore_wb_stage;

    localparam int c_DW = 32;
    localparam int c_AW = 5;
    localparam int c_SW = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mbscore_wb_stage_if #(.DATA_WIDTH(c_DW), .REG_ADDR_WIDTH(c_AW), .SEL_WIDTH(c_SW)) bus ();

    mbscore_wb_stage #(
        .DATA_WIDTH     (c_DW),
        .REG_ADDR_WIDTH (c_AW),
        .SEL_WIDTH      (c_SW),
        .MEM_TIMEOUT    (15),
        .ZERO_REG       (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] sel, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] addr);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_rd    = rd;
        bus.in_alu   = alu;
        bus.in_addr  = addr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({bus.in_ready, bus.mem_req, bus.rf_we, bus.jump, bus.wb_err} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_state got=%b exp=10000",
                     {bus.in_ready, bus.mem_req, bus.rf_we, bus.jump, bus.wb_err});
        end
        rst_n = 1'b1;
        issue(3'd3, 5'd5, 32'h0, 32'h40);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.mem_req, bus.in_ready} !== 2'b10) begin
            failures++;
            $display("FAIL reset_load_start got=%b exp=10", {bus.mem_req, bus.in_ready});
        end
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        checks++;
        if ({bus.mem_req, bus.rf_we, bus.in_ready} !== 3'b001) begin
            failures++;
            $display("FAIL reset_midload got=%b exp=001", {bus.mem_req, bus.rf_we, bus.in_ready});
        end
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1111_2222;
        step();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        checks++;
        if ({bus.rf_we, bus.mem_req, bus.wb_err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_late_resp got=%b exp=000", {bus.rf_we, bus.mem_req, bus.wb_err});
        end
    endtask

    task automatic test_back_to_back();
        issue(3'd1, 5'd3, 32'h0000_00A5, 32'h0);
        step();
        issue(3'd1, 5'd4, 32'h0000_005A, 32'h0);
        checks++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd3, 32'h0000_00A5}) begin
            failures++;
            $display("FAIL b2b_first got=%b/%0d/%h exp=1/3/000000a5",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd4, 32'h0000_005A}) begin
            failures++;
            $display("FAIL b2b_second got=%b/%0d/%h exp=1/4/0000005a",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        step();
        checks++;
        if (bus.rf_we !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got=%b exp=0", bus.rf_we);
        end
    endtask

    task automatic test_jump();
        issue(3'd4, 5'd6, 32'h1, 32'h0);
        step();
        issue(3'd4, 5'd6, 32'h2, 32'h0);
        checks++;
        if ({bus.jump, bus.rf_we, bus.wb_err} !== 3'b100) begin
            failures++;
            $display("FAIL jump_one got=%b exp=100", {bus.jump, bus.rf_we, bus.wb_err});
        end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.jump, bus.rf_we, bus.wb_err} !== 3'b000) begin
            failures++;
            $display("FAIL jump_zero got=%b exp=000", {bus.jump, bus.rf_we, bus.wb_err});
        end
    endtask

    task automatic test_load();
        issue(3'd3, 5'd7, 32'h0, 32'h100);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.in_ready, bus.mem_addr} !== {3'b100, 32'h100}) begin
            failures++;
            $display("FAIL load_req got=%b/%h exp=100/00000100",
                     {bus.mem_req, bus.mem_we, bus.in_ready}, bus.mem_addr);
        end
        step();
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        checks++;
        if ({bus.mem_req, bus.in_ready, bus.rf_we} !== 3'b000) begin
            failures++;
            $display("FAIL load_wait got=%b exp=000", {bus.mem_req, bus.in_ready, bus.rf_we});
        end
        step();
        step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        checks++;
        if (bus.rf_we !== 1'b0) begin
            failures++;
            $display("FAIL load_early_we got=%b exp=0", bus.rf_we);
        end
        step();
        bus.mem_rvalid = 1'b0;
        checks++;
        if ({bus.rf_we, bus.in_ready, bus.rf_waddr, bus.rf_wdata} !== {2'b11, 5'd7, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL load_data got=%b%b/%0d/%h exp=11/7/deadbeef",
                     bus.rf_we, bus.in_ready, bus.rf_waddr, bus.rf_wdata);
        end
        step();
        checks++;
        if (bus.rf_we !== 1'b0) begin
            failures++;
            $display("FAIL load_pulse got=%b exp=0", bus.rf_we);
        end
    endtask

    task automatic test_load_fast_and_store();
        issue(3'd3, 5'd9, 32'h0, 32'h200);
        step();
        bus.in_valid   = 1'b0;
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        step();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        checks++;
        if ({bus.mem_req, bus.in_ready, bus.rf_we, bus.rf_waddr, bus.rf_wdata}
                !== {3'b011, 5'd9, 32'h1234_5678}) begin
            failures++;
            $display("FAIL fast_load got=%b/%0d/%h exp=011/9/12345678",
                     {bus.mem_req, bus.in_ready, bus.rf_we}, bus.rf_waddr, bus.rf_wdata);
        end
        issue(3'd2, 5'd1, 32'hCAFE_F00D, 32'h300);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}
                !== {2'b11, 32'h300, 32'hCAFE_F00D}) begin
            failures++;
            $display("FAIL store_req got=%b/%h/%h exp=11/00000300/cafef00d",
                     {bus.mem_req, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
        end
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        checks++;
        if ({bus.mem_req, bus.rf_we, bus.in_ready, bus.wb_err} !== 4'b0010) begin
            failures++;
            $display("FAIL store_done got=%b exp=0010",
                     {bus.mem_req, bus.rf_we, bus.in_ready, bus.wb_err});
        end
    endtask

    task automatic test_timeout();
        issue(3'd3, 5'd10, 32'h0, 32'h400);
        step();
        bus.in_valid = 1'b0;
        // 15 cycles with mem_req high, the last edge of which aborts
        for (int i = 1; i <= 14; i++) begin
            checks++;
            if ({bus.mem_req, bus.wb_err} !== 2'b10) begin
                failures++;
                $display("FAIL timeout_hold cycle=%0d got=%b exp=10", i, {bus.mem_req, bus.wb_err});
            end
            step();
        end
        checks++;
        if ({bus.mem_req, bus.wb_err} !== 2'b10) begin
            failures++;
            $display("FAIL timeout_last got=%b exp=10", {bus.mem_req, bus.wb_err});
        end
        step();
        checks++;
        if ({bus.wb_err, bus.mem_req, bus.rf_we, bus.in_ready} !== 4'b1001) begin
            failures++;
            $display("FAIL timeout_err got=%b exp=1001",
                     {bus.wb_err, bus.mem_req, bus.rf_we, bus.in_ready});
        end
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h5555_AAAA;
        step();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        checks++;
        if ({bus.wb_err, bus.rf_we, bus.mem_req} !== 3'b000) begin
            failures++;
            $display("FAIL timeout_late got=%b exp=000", {bus.wb_err, bus.rf_we, bus.mem_req});
        end
    endtask

    task automatic test_illegal_and_zero();
        issue(3'd7, 5'd2, 32'hFFFF_FFFF, 32'h500);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.wb_err, bus.rf_we, bus.jump, bus.mem_req, bus.in_ready} !== 5'b10001) begin
            failures++;
            $display("FAIL illegal_sel got=%b exp=10001",
                     {bus.wb_err, bus.rf_we, bus.jump, bus.mem_req, bus.in_ready});
        end
        step();
        checks++;
        if (bus.wb_err !== 1'b0) begin
            failures++;
            $display("FAIL illegal_pulse got=%b exp=0", bus.wb_err);
        end
        issue(3'd1, 5'd0, 32'h0000_00FF, 32'h0);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.rf_we, bus.wb_err, bus.jump} !== 3'b000) begin
            failures++;
            $display("FAIL zero_reg got=%b exp=000", {bus.rf_we, bus.wb_err, bus.jump});
        end
        issue(3'd0, 5'd8, 32'h1, 32'h0);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.rf_we, bus.wb_err, bus.jump, bus.mem_req, bus.in_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL nop got=%b exp=00001",
                     {bus.rf_we, bus.wb_err, bus.jump, bus.mem_req, bus.in_ready});
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_sel     = '0;
        bus.in_rd      = '0;
        bus.in_alu     = '0;
        bus.in_addr    = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;

        test_reset();
        test_back_to_back();
        test_jump();
        test_load();
        test_load_fast_and_store();
        test_timeout();
        test_illegal_and_zero();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
